// File: rtl/vga_pkg.sv
// Shared VGA types and constants used by the frame fetcher and its bench.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    WAIT_VS = 1'b0,
    RUN     = 1'b1
  } fetch_state_e;

  function automatic rgb_t gray_to_rgb(input logic [7:0] gray);
    return '{r: gray, g: gray, b: gray};
  endfunction

endpackage

// File: rtl/frame_fetch_if.sv
// Scan-position, RAM and DAC-side signals of the frame fetcher.
interface frame_fetch_if #(
  parameter int ADDR_W = 17
);
  logic [9:0]        x;
  logic [9:0]        y;
  logic              hsync_in;
  logic              vsync_in;
  logic              blank_b_in;
  logic              bank_req;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic              hsync;
  logic              vsync;
  logic              blank_b;
  logic              bank_sel;
  logic              frame_done;

  modport master (
    output x, y, hsync_in, vsync_in, blank_b_in, bank_req, mem_rdata,
    input  mem_rd, mem_addr, r, g, b, hsync, vsync, blank_b, bank_sel, frame_done
  );

  modport slave (
    input  x, y, hsync_in, vsync_in, blank_b_in, bank_req, mem_rdata,
    output mem_rd, mem_addr, r, g, b, hsync, vsync, blank_b, bank_sel, frame_done
  );
endinterface

// File: rtl/frame_fetch_sync_delay.sv
// Fixed-depth shift register that clears to a chosen idle pattern on reset.
module sync_delay #(
  parameter int             DEPTH   = 2,
  parameter int             W       = 5,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [DEPTH];

  // NOTE: this array is a short register chain, not a RAM, so resetting every stage is cheap and keeps idle syncs on the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/frame_fetch.sv
// Framebuffer pixel fetcher: maps scan position onto a double-banked grayscale
// image, issues RAM reads and realigns syncs with the returned colour.
module frame_fetch
  import vga_pkg::*;
#(
  parameter int          IMG_W      = 256,
  parameter int          IMG_H      = 256,
  parameter int          X0         = 192,
  parameter int          Y0         = 112,
  parameter int          MEM_LAT    = 1,
  parameter logic [23:0] BORDER_RGB = 24'h000040
) (
  input logic           clk,
  input logic           rst,
  frame_fetch_if.slave  bus
);

  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);
  localparam int ADDR_W = 1 + XW + YW;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_b;
    logic in_win;
    logic run;
  } flags_t;

  localparam flags_t FLAGS_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_b: 1'b0, in_win: 1'b0, run: 1'b0};

  fetch_state_e      r_state, w_state_next;
  logic              r_vs_prev;
  logic              r_bank_sel;
  logic              r_frame_done;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  rgb_t              r_rgb;
  logic              r_hsync, r_vsync, r_blank_b;

  logic              w_x_hit, w_y_hit, w_in_win, w_fetch;
  logic [XW-1:0]     w_x_off;
  logic [YW-1:0]     w_y_off;
  logic              w_frame_edge, w_bank_load, w_frame_done;
  flags_t            w_flags_in, w_flags_tap;
  rgb_t              w_rgb_next;

  assign w_x_hit  = (bus.x >= 10'(X0)) && ({1'b0, bus.x} < 11'(X0 + IMG_W));
  assign w_y_hit  = (bus.y >= 10'(Y0)) && ({1'b0, bus.y} < 11'(Y0 + IMG_H));
  assign w_in_win = bus.blank_b_in && w_x_hit && w_y_hit;
  assign w_x_off  = XW'(bus.x - 10'(X0));
  assign w_y_off  = YW'(bus.y - 10'(Y0));
  assign w_fetch  = w_in_win && (r_state == RUN);

  // Previous vsync clears to 0 so a vsync already low at reset release is not taken as a frame edge.
  assign w_frame_edge = r_vs_prev && !bus.vsync_in;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_bank_load  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      WAIT_VS: if (w_frame_edge) begin
        w_state_next = RUN;
        w_bank_load  = 1'b1;
      end
      RUN: if (w_frame_edge) begin
        w_bank_load  = 1'b1;
        w_frame_done = 1'b1;
      end
      default: w_state_next = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WAIT_VS;
      r_vs_prev    <= 1'b0;
      r_bank_sel   <= 1'b0;
      r_frame_done <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_vs_prev    <= bus.vsync_in;
      r_frame_done <= w_frame_done;
      r_mem_rd     <= w_fetch;
      if (w_bank_load) r_bank_sel <= bus.bank_req;
      if (w_fetch)     r_mem_addr <= {r_bank_sel, w_y_off, w_x_off};
    end
  end

  // Flags travel alongside the read so they meet mem_rdata at the output register.
  assign w_flags_in = '{hsync:   bus.hsync_in,
                        vsync:   bus.vsync_in,
                        blank_b: bus.blank_b_in,
                        in_win:  w_in_win,
                        run:     (r_state == RUN)};

  sync_delay #(
    .DEPTH   (MEM_LAT + 1),
    .W       ($bits(flags_t)),
    .RST_VAL (FLAGS_IDLE)
  ) u_flag_dly (
    .clk (clk),
    .rst (rst),
    .i_d (w_flags_in),
    .o_q (w_flags_tap)
  );

  always_comb begin
    w_rgb_next = '0;
    if (w_flags_tap.blank_b && w_flags_tap.run)
      w_rgb_next = w_flags_tap.in_win ? gray_to_rgb(bus.mem_rdata) : rgb_t'(BORDER_RGB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb     <= '0;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_b <= 1'b0;
    end else begin
      r_rgb     <= w_rgb_next;
      r_hsync   <= w_flags_tap.hsync;
      r_vsync   <= w_flags_tap.vsync;
      r_blank_b <= w_flags_tap.blank_b;
    end
  end

  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.r          = r_rgb.r;
  assign bus.g          = r_rgb.g;
  assign bus.b          = r_rgb.b;
  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.blank_b    = r_blank_b;
  assign bus.bank_sel   = r_bank_sel;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_fetch.sv
// Bench for frame_fetch: MEM_LAT=1 and MEM_LAT=3 builds share one stimulus
// stream and are compared against a per-input-cycle reference of the pixel rules.
module tb_frame_fetch;
  import vga_pkg::*;

  localparam int AW = 17;
  localparam int X0 = 192;
  localparam int Y0 = 112;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0] x, y;
  logic hs, vs, bl, breq;

  frame_fetch_if #(.ADDR_W(AW)) bus1 ();
  frame_fetch_if #(.ADDR_W(AW)) bus3 ();

  assign bus1.x = x;  assign bus1.y = y;  assign bus1.hsync_in = hs;
  assign bus1.vsync_in = vs;  assign bus1.blank_b_in = bl;  assign bus1.bank_req = breq;
  assign bus3.x = x;  assign bus3.y = y;  assign bus3.hsync_in = hs;
  assign bus3.vsync_in = vs;  assign bus3.blank_b_in = bl;  assign bus3.bank_req = breq;

  frame_fetch #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  frame_fetch #(.MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  // RAM models: data is only meaningful MEM_LAT cycles after a read strobe, 8'hEE otherwise.
  logic [7:0] mem [2**AW];
  logic [7:0] d1;     logic v1;
  logic [7:0] d3 [3]; logic v3 [3];
  always @(posedge clk) begin
    d1 <= mem[bus1.mem_addr];  v1 <= bus1.mem_rd;
    d3[0] <= mem[bus3.mem_addr];  v3[0] <= bus3.mem_rd;
    d3[1] <= d3[0];  v3[1] <= v3[0];
    d3[2] <= d3[1];  v3[2] <= v3[1];
  end
  assign bus1.mem_rdata = v1 ? d1 : 8'hEE;
  assign bus3.mem_rdata = v3[2] ? d3[2] : 8'hEE;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  always @(negedge clk) if (bus1.frame_done) fd_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived from each input cycle.
  typedef struct {
    logic        hs, vs, bl;
    logic [23:0] rgb;
    logic        rd;
    logic [16:0] addr;
    logic        fd;
    logic        bank;
  } exp_t;

  exp_t        ring [16];
  int          n;
  bit          m_prev_vs, m_run, m_bank;
  logic [16:0] m_last_addr;

  task automatic model_reset();
    for (int i = 0; i < 16; i++)
      ring[i] = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, rgb: 24'h0, rd: 1'b0, addr: 17'h0, fd: 1'b0, bank: 1'b0};
    m_prev_vs = 1'b0;  m_run = 1'b0;  m_bank = 1'b0;  m_last_addr = '0;
  endtask

  // One pixel clock: apply inputs, predict, advance, compare both builds.
  task automatic cycle(input logic [9:0] cx, input logic [9:0] cy,
                       input logic chs, input logic cvs, input logic cbl, input logic cbr);
    exp_t e;
    bit win, fedge;
    logic [16:0] a;
    x = cx;  y = cy;  hs = chs;  vs = cvs;  bl = cbl;  breq = cbr;
    win = cbl && (int'(cx) >= X0) && (int'(cx) < X0 + 256) && (int'(cy) >= Y0) && (int'(cy) < Y0 + 256);
    a = {m_bank, 8'(int'(cy) - Y0), 8'(int'(cx) - X0)};
    e.hs = chs;  e.vs = cvs;  e.bl = cbl;
    e.rd = win && m_run;
    if (e.rd) m_last_addr = a;
    e.addr = m_last_addr;
    if (!cbl || !m_run) e.rgb = 24'h0;
    else if (win)       e.rgb = {3{mem[a]}};
    else                e.rgb = 24'h000040;
    fedge = m_prev_vs && !cvs;
    e.fd = fedge && m_run;
    if (fedge) begin m_run = 1'b1; m_bank = cbr; end
    e.bank = m_bank;
    m_prev_vs = cvs;
    ring[n & 15] = e;
    @(posedge clk); #1;
    n++;
    e = ring[(n - 1) & 15];
    check("rd1", bus1.mem_rd, e.rd);      check("rd3", bus3.mem_rd, e.rd);
    check("addr1", bus1.mem_addr, e.addr); check("addr3", bus3.mem_addr, e.addr);
    check("fd1", bus1.frame_done, e.fd);  check("fd3", bus3.frame_done, e.fd);
    check("bank1", bus1.bank_sel, e.bank); check("bank3", bus3.bank_sel, e.bank);
    e = ring[(n - 3) & 15];
    check("rgb1", {bus1.r, bus1.g, bus1.b}, e.rgb);
    check("sync1", {bus1.hsync, bus1.vsync, bus1.blank_b}, {e.hs, e.vs, e.bl});
    e = ring[(n - 5) & 15];
    check("rgb3", {bus3.r, bus3.g, bus3.b}, e.rgb);
    check("sync3", {bus3.hsync, bus3.vsync, bus3.blank_b}, {e.hs, e.vs, e.bl});
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(10'd700, 10'd490, 1'b1, 1'b1, 1'b0, breq);
  endtask

  task automatic vsync_pulse(input logic br);
    idle(3);
    for (int i = 0; i < 4; i++) cycle(10'd700, 10'd491, 1'b1, 1'b0, 1'b0, br);
    idle(3);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd"},   {bus1.mem_rd, bus3.mem_rd}, 2'b00);
    check({tag, "_addr"}, bus1.mem_addr | bus3.mem_addr, 17'h0);
    check({tag, "_rgb"},  {bus1.r, bus1.g, bus1.b} | {bus3.r, bus3.g, bus3.b}, 24'h0);
    check({tag, "_sync"}, {bus1.hsync, bus1.vsync, bus1.blank_b, bus3.hsync, bus3.vsync, bus3.blank_b}, 6'b110110);
    check({tag, "_bank_fd"}, {bus1.bank_sel, bus1.frame_done, bus3.bank_sel, bus3.frame_done}, 4'b0000);
  endtask

  typedef struct {
    logic [9:0]  vx, vy;
    logic        vbl;
    logic        erd;
    logic [16:0] eaddr;
    logic [23:0] ergb;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int fd_before;
    for (int a = 0; a < 2**AW; a++)
      mem[a] = 8'(a[7:0] + a[15:8] + (a[16] ? 8'h80 : 8'h00));
    mem[17'h00000] = 8'hC3;
    mem[17'h0FFFF] = 8'h5A;

    vecs[0] = '{vx: 10'd192, vy: 10'd112, vbl: 1'b1, erd: 1'b1, eaddr: 17'h00000, ergb: 24'hC3C3C3};
    vecs[1] = '{vx: 10'd447, vy: 10'd367, vbl: 1'b1, erd: 1'b1, eaddr: 17'h0FFFF, ergb: 24'h5A5A5A};
    vecs[2] = '{vx: 10'd191, vy: 10'd200, vbl: 1'b1, erd: 1'b0, eaddr: 17'h0FFFF, ergb: 24'h000040};
    vecs[3] = '{vx: 10'd448, vy: 10'd200, vbl: 1'b1, erd: 1'b0, eaddr: 17'h0FFFF, ergb: 24'h000040};
    vecs[4] = '{vx: 10'd700, vy: 10'd200, vbl: 1'b0, erd: 1'b0, eaddr: 17'h0FFFF, ergb: 24'h000000};
    vecs[5] = '{vx: 10'd300, vy: 10'd111, vbl: 1'b1, erd: 1'b0, eaddr: 17'h0FFFF, ergb: 24'h000040};
    vecs[6] = '{vx: 10'd300, vy: 10'd368, vbl: 1'b1, erd: 1'b0, eaddr: 17'h0FFFF, ergb: 24'h000040};
    vecs[7] = '{vx: 10'd320, vy: 10'd130, vbl: 1'b0, erd: 1'b0, eaddr: 17'h0FFFF, ergb: 24'h000000};
    vecs[8] = '{vx: 10'd200, vy: 10'd113, vbl: 1'b1, erd: 1'b1, eaddr: 17'h00108, ergb: 24'h090909};

    rst = 1'b1;
    x = 10'd700;  y = 10'd490;  hs = 1'b1;  vs = 1'b1;  bl = 1'b0;  breq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    model_reset();
    n = 16;

    // Two frames with vsync held high: no fetch, black output, syncs pass through.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 60; i++)
        cycle(10'($urandom_range(150, 500)), 10'($urandom_range(100, 380)), 1'($urandom), 1'b1, 1'b1, 1'b0);
    check("wait_no_rd", bus1.mem_rd, 1'b0);

    vsync_pulse(1'b0);

    foreach (vecs[i]) begin
      cycle(vecs[i].vx, vecs[i].vy, 1'b1, 1'b1, vecs[i].vbl, 1'b0);
      check($sformatf("vec%0d_rd", i), bus1.mem_rd, vecs[i].erd);
      check($sformatf("vec%0d_addr", i), bus1.mem_addr, vecs[i].eaddr);
      idle(2);
      check($sformatf("vec%0d_rgb1", i), {bus1.r, bus1.g, bus1.b}, vecs[i].ergb);
      idle(2);
      check($sformatf("vec%0d_rgb3", i), {bus3.r, bus3.g, bus3.b}, vecs[i].ergb);
    end

    // Full-line ramp on the first image row of bank 0.
    for (int cx = 150; cx <= 500; cx++) cycle(10'(cx), 10'd112, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(5);

    // Bank request mid-frame takes effect only at the next frame edge.
    for (int i = 0; i < 40; i++) cycle(10'(200 + i), 10'd150, 1'b1, 1'b1, 1'b1, 1'b1);
    check("bank_hold", bus1.bank_sel, 1'b0);
    fd_before = fd_cnt;
    vsync_pulse(1'b1);
    check("fd_once", fd_cnt - fd_before, 1);
    check("bank_switch", bus1.bank_sel, 1'b1);
    cycle(10'd192, 10'd112, 1'b1, 1'b1, 1'b1, 1'b0);
    check("bank1_origin", bus1.mem_addr, 17'h10000);
    idle(5);

    // Random traffic with frame edges kept inside vertical blank.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 250; i++)
        cycle(10'($urandom_range(150, 500)), 10'($urandom_range(90, 400)), 1'($urandom),
              1'b1, 1'(($urandom % 8) != 0), 1'($urandom));
      vsync_pulse(1'($urandom));
    end

    // One-cycle reset in the middle of a fetching line.
    for (int i = 0; i < 20; i++) cycle(10'(250 + i), 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 30; i++) cycle(10'(250 + i), 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    check("midreset_no_rd", bus1.mem_rd | bus3.mem_rd, 1'b0);
    vsync_pulse(1'b0);
    cycle(10'd260, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    check("refetch_rd", bus1.mem_rd & bus3.mem_rd, 1'b1);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
